// File: rtl/bus_proc_pkg.sv
// Shared definitions for the shared-bus processor control unit: instruction
// field layout, opcode constants and the step-state encoding.
package bus_proc_pkg;

    localparam int unsigned NREG   = 8;    // general registers R0-R7
    localparam int unsigned IW     = 9;    // instruction width
    localparam int unsigned OPW    = 3;    // opcode field width
    localparam int unsigned RW     = 3;    // register-select field width
    localparam int unsigned OP_LSB = 6;    // opcode = instr[8:6]
    localparam int unsigned X_LSB  = 3;    // X      = instr[5:3]
    localparam int unsigned Y_LSB  = 0;    // Y      = instr[2:0]

    localparam logic [OPW-1:0] OP_MV  = 3'b000;
    localparam logic [OPW-1:0] OP_MVI = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_SUB = 3'b011;

    // HALT is only reachable when the illegal-opcode trap is built in
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } step_e;

endpackage

// File: rtl/bus_proc_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable.
//   en     : when 0 the output is all zeros
//   sel    : 3-bit index
//   onehot : bit sel set when enabled
module dec3to8
    import bus_proc_pkg::*;
(
    input  logic            en,
    input  logic [RW-1:0]   sel,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_proc_ctrl.sv
// Control unit for the shared-bus register-transfer datapath. Latches an
// instruction into IR when run is seen in T0 and sequences it over T1-T3,
// driving one-hot bus-source / register-load enables (Moore decode of step+IR).
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes trap into a sticky
// HALT state that raises illegal; otherwise they are one-cycle nops.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   run, instr      : start request (sampled in T0) and instruction word
//   ir_in           : IR load enable
//   r_out / r_in    : one-hot register bus-drive / bus-load enables
//   din_out, g_out  : DIN / G drive the bus
//   a_in, g_in      : A loads bus, G loads adder result
//   addsub          : 0 = add, 1 = subtract (valid with g_in)
//   done            : final step of the instruction
//   illegal         : trapped on an undefined opcode
module bus_proc_ctrl
    import bus_proc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [IW-1:0]   instr,
    output logic            ir_in,
    output logic [NREG-1:0] r_out,
    output logic [NREG-1:0] r_in,
    output logic            din_out,
    output logic            g_out,
    output logic            a_in,
    output logic            g_in,
    output logic            addsub,
    output logic            done,
    output logic            illegal
);

    step_e           state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   fx, fy;
    logic [NREG-1:0] x_oh, y_oh;
    logic            busy;

    assign op   = ir_q[OP_LSB +: OPW];
    assign fx   = ir_q[X_LSB  +: RW];
    assign fy   = ir_q[Y_LSB  +: RW];
    assign busy = (state_q != T0);

    // Register selects are only meaningful once IR holds a live instruction
    dec3to8 u_dec_x (.en(busy), .sel(fx), .onehot(x_oh));
    dec3to8 u_dec_y (.en(busy), .sel(fy), .onehot(y_oh));

    // Reset gates ir_in so every output is quiet while reset is held
    assign ir_in = (state_q == T0) && run && !reset;
    assign ir_d  = ir_in ? instr : ir_q;

    // State and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-step sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: if (run) state_d = T1;
            T1: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    state_d = T2;
                end else if (op == OP_MV || op == OP_MVI) begin
                    state_d = T0;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = T0;
`endif
                end
            end
            T2:      state_d = T3;
            T3:      state_d = T0;
`ifdef ILLEGAL_TRAP_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = T0;
        endcase
    end

    // Moore output decode from step and IR
    always_comb begin
        r_out   = '0;
        r_in    = '0;
        din_out = 1'b0;
        g_out   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        case (state_q)
            T1: begin
                case (op)
                    OP_MV: begin
                        r_out = y_oh;
                        r_in  = x_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out = x_oh;
                        a_in  = 1'b1;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        done = 1'b0;
`else
                        done = 1'b1;
`endif
                    end
                endcase
            end
            T2: begin
                r_out  = y_oh;
                g_in   = 1'b1;
                addsub = (op == OP_SUB);
            end
            T3: begin
                g_out = 1'b1;
                r_in  = x_oh;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    // HALT is left only through reset, so the state itself is the sticky flag
    assign illegal = (state_q == HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_bus_proc_ctrl.sv
// Scoreboard bench for bus_proc_ctrl: each issued instruction pushes the
// expected per-cycle output vectors, which are popped one per clock.
module tb_bus_proc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [8:0] instr;
    logic       ir_in;
    logic [7:0] r_out;
    logic [7:0] r_in;
    logic       din_out, g_out, a_in, g_in, addsub, done, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_q[$];
    logic [23:0] act;

    always #5 clk = ~clk;

    bus_proc_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .ir_in(ir_in), .r_out(r_out), .r_in(r_in), .din_out(din_out),
        .g_out(g_out), .a_in(a_in), .g_in(g_in), .addsub(addsub),
        .done(done), .illegal(illegal)
    );

    assign act = {ir_in, r_out, r_in, din_out, g_out, a_in, g_in, addsub, done, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // {ir_in, r_out, r_in, din_out, g_out, a_in, g_in, addsub, done, illegal}
    function automatic logic [23:0] vec(input logic [7:0] ro, input logic [7:0] ri,
                                        input logic dn, input logic go, input logic ai,
                                        input logic gi, input logic as, input logic dne,
                                        input logic ill);
        return {1'b0, ro, ri, dn, go, ai, gi, as, dne, ill};
    endfunction

    function automatic logic [7:0] oh(input logic [2:0] i);
        logic [7:0] one;
        one = 8'h01;
        return one << i;
    endfunction

    task automatic sample(input string tag);
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(act), 32'(e));
        end
        chk({tag, "_onebus"}, 32'(($countones({r_out, din_out, g_out}) <= 1)), 32'd1);
    endtask

    // Issue one instruction from T0, checking every step and the return to T0
    task automatic issue(input logic [8:0] w, input bit trap);
        logic [2:0] op, x, y;
        int n;
        op = w[8:6];
        x  = w[5:3];
        y  = w[2:0];
        instr = w;
        run   = 1'b1;
        #1;
        chk($sformatf("ir_in_%h", w), 32'(ir_in), 32'd1);
        case (op)
            3'b000: exp_q.push_back(vec(oh(y), oh(x), 0, 0, 0, 0, 0, 1, 0));
            3'b001: exp_q.push_back(vec(8'h00, oh(x), 1, 0, 0, 0, 0, 1, 0));
            3'b010, 3'b011: begin
                exp_q.push_back(vec(oh(x), 8'h00, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(vec(oh(y), 8'h00, 0, 0, 0, 1, op[0], 0, 0));
                exp_q.push_back(vec(8'h00, oh(x), 0, 1, 0, 0, 0, 1, 0));
            end
            default: begin
                if (trap) begin
                    exp_q.push_back(vec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
                    for (int k = 0; k < 5; k++)
                        exp_q.push_back(vec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
                end else begin
                    exp_q.push_back(vec(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0));
                end
            end
        endcase
        if (!trap) exp_q.push_back(24'h0);  // idle T0 with run low
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            sample($sformatf("i%h_s%0d", w, i));
            if (i == 0) instr = ~w;  // IR must hold the latched word
            if (!trap && i == n - 2) run = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        instr = 9'h1FF;
        // Reset with run high: everything quiet
        repeat (2) begin
            exp_q.push_back(24'h0);
            sample("reset");
        end
        reset = 1'b0;
        run   = 1'b0;
        exp_q.push_back(24'h0);
        sample("idle");

        issue(9'h048, 1'b0);  // mvi R1
        issue(9'h015, 1'b0);  // mv R2,R5
        issue(9'h081, 1'b0);  // add R0,R1
        issue(9'h0DC, 1'b0);  // sub R3,R4
        issue(9'h01B, 1'b0);  // mv R3,R3

        // Abort an add in T2 with reset
        instr = 9'h081;
        run   = 1'b1;
        exp_q.push_back(vec(8'h01, 8'h00, 0, 0, 1, 0, 0, 0, 0));
        sample("abort_t1");
        run = 1'b0;
        exp_q.push_back(vec(8'h02, 8'h00, 0, 0, 0, 1, 0, 0, 0));
        sample("abort_t2");
        reset = 1'b1;
        exp_q.push_back(24'h0);
        sample("abort_rst");
        reset = 1'b0;
        issue(9'h070, 1'b0);  // mvi R6 right after the abort

`ifdef ILLEGAL_TRAP_EN
        issue(9'h1C0, 1'b1);
        run   = 1'b0;
        reset = 1'b1;
        exp_q.push_back(24'h0);
        sample("trap_clear");
        reset = 1'b0;
        issue(9'h048, 1'b0);
`else
        issue(9'h1C0, 1'b0);
        issue(9'h130, 1'b0);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_proc_ctrl.md
Name: bus_proc_ctrl

Overview:
Control unit for the shared-bus register-transfer datapath: eight general registers R0-R7, adder operand register A, result register G, external data input DIN, one common bus. Latches a 9-bit instruction on run and sequences it over time steps T0-T3. Drives one-hot bus-source and register-load enables each cycle and pulses done on the final step. Sits between the instruction source and the datapath; contains no data registers except the instruction register IR.

Parameters:
NREG, 8, number of general registers; fixed at 8 because the X/Y fields are 3 bits.
IW, 9, instruction width: opcode[8:6], X[5:3], Y[2:0].

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high.
run  in  1  start request; sampled only in T0.
instr  in  IW  instruction word; captured into IR when ir_in=1.
ir_in  out  1  IR load enable; visible for datapath/debug.
r_out  out  NREG  one-hot: register Ri drives the bus.
r_in  out  NREG  one-hot: register Ri loads from the bus.
din_out  out  1  DIN drives the bus.
g_out  out  1  G drives the bus.
a_in  out  1  A loads from the bus.
g_in  out  1  G loads the adder result.
addsub  out  1  0 = A+bus, 1 = A-bus; meaningful only while g_in=1.
done  out  1  final step of the instruction.
illegal  out  1  undefined opcode indication; see Optional Feature.

Behaviour:
- Step counter with states T0, T1, T2, T3. Reset forces T0 and IR=0, and all outputs 0 in the following cycle. Reset mid-instruction aborts it with no done.
- T0:
  - ir_in = run; every other output is 0.
  - run=1 loads instr into IR and moves to T1.
  - run=0 stays in T0.
- run is ignored in T1-T3. IR is stable from T1 until the next T0 load.
- Opcodes and steps (X = IR[5:3], Y = IR[2:0]):
  - 000 mv X,Y: T1 r_out[Y], r_in[X], done; then T0.
  - 001 mvi X,DIN: T1 din_out, r_in[X], done; then T0.
  - 010 add X,Y:
    - T1 r_out[X], a_in.
    - T2 r_out[Y], g_in, addsub=0.
    - T3 g_out, r_in[X], done; then T0.
  - 011 sub X,Y: same as add, but addsub=1 in T2.
  - 100-111 undefined: T1 done only, no bus source, no load; then T0.
- mv X,X is legal: r_out[X] and r_in[X] are both asserted.
- Outputs are decoded combinationally from the step and IR only (Moore); there is no input-to-output path except ir_in.
- Latency from run sample: mv/mvi done 1 cycle later; add/sub done 3 cycles later. Back-to-back instructions are possible because T0 always follows done.
- Invariant: at most one of {r_out bits, din_out, g_out} is high in any cycle. done is high for exactly one cycle per instruction.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - An undefined opcode in T1 sets a sticky illegal flag and moves to a HALT state.
  - HALT drives all outputs 0 except illegal=1 and ignores run. No done is issued.
  - Only reset clears the flag and HALT.
- Not defined: illegal is tied to 0 and undefined opcodes behave as the one-cycle nop described above.

Decomposition:
- Package bus_proc_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - the step enum (T0-T3, plus HALT);
  - field width/position constants.
- Sub-module dec3to8: 3-bit to 8-bit one-hot decoder with enable, instantiated twice (X and Y).

Test Plan:
- reset=1 for 2 cycles with run=1 -> state T0, all outputs 0, IR=0, no done.
- instr=9'h048 (mvi R1), run pulsed -> next cycle: din_out=1, r_in=8'h02, done=1; next cycle back to T0.
- instr=9'h015 (mv R2,R5) -> T1: r_out=8'h20, r_in=8'h04, done=1. Also check exactly one bus driver each cycle.
- instr=9'h081 (add R0,R1):
  - T1 r_out=8'h01, a_in=1.
  - T2 r_out=8'h02, g_in=1, addsub=0.
  - T3 g_out=1, r_in=8'h01, done=1.
  - Repeat with 9'h0DC (sub R3,R4): addsub=1 in T2, r_in=8'h08 in T3.
- Reset asserted in T2 of an add -> next cycle T0, no done, no r_in. Then mvi issued back-to-back completes normally.
- instr=9'h1C0:
  - Without ILLEGAL_TRAP_EN -> T1 done=1 only, illegal=0.
  - With it -> illegal=1 sticky and run ignored for 5 cycles, until reset clears.
